coproc_scheduler: RTL

Shares one CPU-side command/result path among four coprocessor units on the 2-bit device-address bus.
- Dispatches 32-bit command words to the addressed unit and tracks per-unit busy state.
- Captures one-cycle result pulses into per-unit hold registers.
- Drains held results round-robin into a result FIFO that the CPU pops, with one irq pulse per queued result.

---
 rtl/coproc_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/coproc_scheduler.sv
// Command dispatch and result collection for four coprocessor units sharing one CPU port.
// Completed results are held per unit, drained round-robin into a FIFO, and signalled by irq.
module coproc_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    input  logic [31:0]        cmd_word,
    output logic               cmd_ready,
    output logic [3:0]         u_start,
    output logic [23:0]        u_arg,
    input  logic [3:0]         u_done,
    input  logic [95:0]        u_result,
    output logic               res_valid,
    output logic [31:0]        res_word,
    input  logic               res_ack,
    output logic               irq,
    output logic [3:0]         busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               err_overflow
);

    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [3:0]         pending;
    logic [23:0]        hold [4];
    logic [1:0]         rr_ptr;
    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    logic [1:0] cmd_id;
    logic       accept;
    logic [3:0] start_mask;
    logic [3:0] capture;
    logic       err_set;
    logic       pop;
    logic       space;
    logic       drain;
    logic [1:0] grant;
    logic       grant_valid;
    logic [1:0] search_idx;
    logic [3:0] drain_mask;
    logic       cmd_unused;

    assign cmd_id     = cmd_word[31:30];
    assign cmd_unused = ^cmd_word[29:24];
    assign cmd_ready  = ~busy[cmd_id];
    assign accept     = cmd_valid & cmd_ready;
    assign start_mask = accept ? (4'b0001 << cmd_id) : 4'b0000;

    // A done pulse is only meaningful for a busy unit whose hold register is free.
    assign capture    = u_done & busy & ~pending;
    assign err_set    = |(u_done & ~(busy & ~pending));

    assign res_valid  = (fifo_count != '0);
    assign res_word   = res_valid ? fifo_mem[rd_ptr] : 32'h0;
    assign pop        = res_ack & res_valid;
    assign space      = (fifo_count < FULL_COUNT) | pop;

    // Round-robin search starting just after the last granted unit.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 2'd0;
        search_idx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            search_idx = rr_ptr + 2'(k);
            if (!grant_valid && pending[search_idx]) begin
                grant_valid = 1'b1;
                grant       = search_idx;
            end
        end
    end

    assign drain      = space & grant_valid;
    assign drain_mask = drain ? (4'b0001 << grant) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= 4'b0000;
            pending      <= 4'b0000;
            u_start      <= 4'b0000;
            u_arg        <= 24'h0;
            irq          <= 1'b0;
            err_overflow <= 1'b0;
            rr_ptr       <= 2'd3;
            for (int i = 0; i < 4; i++) begin
                hold[i] <= 24'h0;
            end
        end else begin
            busy         <= (busy | start_mask) & ~drain_mask;
            pending      <= (pending | capture) & ~drain_mask;
            u_start      <= start_mask;
            irq          <= drain;
            err_overflow <= err_overflow | err_set;
            if (accept) begin
                u_arg <= cmd_word[23:0];
            end
            if (drain) begin
                rr_ptr <= grant;
            end
            for (int i = 0; i < 4; i++) begin
                if (capture[i]) begin
                    hold[i] <= u_result[24*i +: 24];
                end
            end
        end
    end

    // Result FIFO; a push and pop on the same edge leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= 32'h0;
            end
        end else begin
            if (drain) begin
                fifo_mem[wr_ptr] <= {1'b1, grant, 5'b00000, hold[grant]};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drain && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!drain && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

endmodule
